// File: rtl/conv_acc_bank_if.sv
// Stream interface of conv_acc_bank: partial-sum input beats and the registered result output.
// master drives beats and out_ready; slave is the accumulator.
interface conv_acc_bank_if #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned PLANE_AW = 3
);
  logic                in_valid;
  logic                in_ready;
  logic                in_first;
  logic                in_last;
  logic [DATA_W-1:0]   sum_muladd;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic [PLANE_AW-1:0] out_plane;

  modport master (
    output in_valid, in_first, in_last, sum_muladd, out_ready,
    input  in_ready, out_valid, out_data, out_plane
  );

  modport slave (
    input  in_valid, in_first, in_last, sum_muladd, out_ready,
    output in_ready, out_valid, out_data, out_plane
  );
endinterface

// File: rtl/conv_acc_bank.sv
// Bias-adding framed accumulator with per-plane bias table and registered valid/ready output.
// Define ACC_SAT_EN to clamp results to DATA_W and enable the sticky sat flag.
module conv_acc_bank #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ACC_W      = 24,
  parameter int unsigned NUM_PLANES = 6,
  localparam int unsigned PLANE_AW  = $clog2(NUM_PLANES)
) (
  input  logic                clk,
  input  logic                rst_n,
  conv_acc_bank_if.slave      bus,
  input  logic                plane_rdy_i,
  input  logic                bias_we_i,
  input  logic [PLANE_AW-1:0] bias_addr_i,
  input  logic [DATA_W-1:0]   bias_data_i,
  output logic                err_o,
  output logic                sat_o
);

  typedef enum logic [0:0] {StIdle, StAcc} state_e;

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [PLANE_AW-1:0] plane_q, plane_d;
  logic [PLANE_AW-1:0] frame_plane_q, frame_plane_d;
  logic [DATA_W-1:0]   bias_q [NUM_PLANES];
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [PLANE_AW-1:0] out_plane_q, out_plane_d;
  logic                err_q, err_d;

  logic                in_ready;
  logic                accept;
  logic                load_out;
  logic [ACC_W-1:0]    sum_ext;
  logic [ACC_W-1:0]    bias_ext;
  logic [ACC_W-1:0]    acc_next;
  logic [DATA_W-1:0]   conv_data;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign sum_ext  = ACC_W'($signed(bus.sum_muladd));
  assign bias_ext = ACC_W'($signed(bias_q[plane_q]));
  // A first beat always restarts from the bias, even when it aborts an open frame.
  assign acc_next = bus.in_first ? (bias_ext + sum_ext) : (acc_q + sum_ext);

`ifdef ACC_SAT_EN
  localparam logic [DATA_W-1:0] MaxVal = {1'b0, {(DATA_W-1){1'b1}}};
  logic [ACC_W-DATA_W:0] top_bits;
  logic                  sat_hit;
  logic                  sat_q;

  // Value fits in DATA_W only when every bit above the result sign matches it.
  assign top_bits  = acc_next[ACC_W-1:DATA_W-1];
  assign sat_hit   = !((&top_bits) || !(|top_bits));
  assign conv_data = !sat_hit ? acc_next[DATA_W-1:0] :
                     (acc_next[ACC_W-1] ? ~MaxVal : MaxVal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (load_out && sat_hit) begin
      sat_q <= 1'b1;
    end
  end

  assign sat_o = sat_q;
`else
  assign conv_data = acc_next[DATA_W-1:0];
  assign sat_o     = 1'b0;
`endif

  assign plane_d = !plane_rdy_i ? plane_q :
                   (plane_q == PLANE_AW'(NUM_PLANES - 1)) ? '0 : plane_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    frame_plane_d = frame_plane_q;
    err_d         = err_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_plane_d   = out_plane_q;
    load_out      = 1'b0;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      unique case (state_q)
        StIdle:  if (!bus.in_first) err_d = 1'b1;
        StAcc:   if (bus.in_first) err_d = 1'b1;
        default: ;
      endcase

      // Beats outside a frame that do not open one are dropped.
      if (bus.in_first || state_q == StAcc) begin
        acc_d = acc_next;
        if (bus.in_first) begin
          frame_plane_d = plane_q;
        end
        if (bus.in_last) begin
          load_out    = 1'b1;
          out_valid_d = 1'b1;
          out_data_d  = conv_data;
          out_plane_d = bus.in_first ? plane_q : frame_plane_q;
          state_d     = StIdle;
        end else begin
          state_d = StAcc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      acc_q         <= '0;
      plane_q       <= '0;
      frame_plane_q <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_plane_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      plane_q       <= plane_d;
      frame_plane_q <= frame_plane_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_plane_q   <= out_plane_d;
      err_q         <= err_d;
    end
  end

  // Registered table: a same-cycle read of the written entry sees the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PLANES; i++) begin
        bias_q[i] <= '0;
      end
    end else if (bias_we_i) begin
      for (int i = 0; i < NUM_PLANES; i++) begin
        if (bias_addr_i == PLANE_AW'(i)) begin
          bias_q[i] <= bias_data_i;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_plane = out_plane_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_conv_acc_bank.sv
// Self-checking bench for conv_acc_bank: table-driven frames plus hand sequences for
// plane wrap, plane/first coincidence, backpressure, restart and reset.
module tb_conv_acc_bank;

  localparam int unsigned DataW  = 16;
  localparam int unsigned AccW   = 24;
  localparam int unsigned Planes = 6;
  localparam int unsigned PlaneAw = 3;
`ifdef ACC_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic plane_rdy = 1'b0;
  logic bias_we = 1'b0;
  logic [PlaneAw-1:0] bias_addr = '0;
  logic [DataW-1:0] bias_data = '0;
  logic err;
  logic sat;

  conv_acc_bank_if #(.DATA_W(DataW), .PLANE_AW(PlaneAw)) bus ();

  conv_acc_bank #(.DATA_W(DataW), .ACC_W(AccW), .NUM_PLANES(Planes)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .plane_rdy_i (plane_rdy),
    .bias_we_i   (bias_we),
    .bias_addr_i (bias_addr),
    .bias_data_i (bias_data),
    .err_o       (err),
    .sat_o       (sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DataW-1:0]   data;
    logic [PlaneAw-1:0] plane;
  } exp_t;

  typedef struct {
    logic [DataW-1:0] bias;
    logic [DataW-1:0] s0;
    logic [DataW-1:0] s1;
    logic [DataW-1:0] s2;
    int               n;
    logic [DataW-1:0] exp;
    logic             exp_sat;
  } vec_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: the handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got data %0h plane %0d, expected no output",
                 bus.out_data, bus.out_plane);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_data", bus.out_data, e.data);
        check("sb_plane", bus.out_plane, e.plane);
      end
    end
  end

  task automatic send_beat(input logic f, input logic l, input logic [DataW-1:0] d);
    int n = 0;
    bus.in_valid   = 1'b1;
    bus.in_first   = f;
    bus.in_last    = l;
    bus.sum_muladd = d;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("beat_timeout", 32'(n), 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic write_bias(input logic [PlaneAw-1:0] a, input logic [DataW-1:0] d);
    bias_we   = 1'b1;
    bias_addr = a;
    bias_data = d;
    @(posedge clk);
    #1;
    bias_we = 1'b0;
  endtask

  task automatic pulse_plane(input int n);
    for (int i = 0; i < n; i++) begin
      plane_rdy = 1'b1;
      @(posedge clk);
      #1;
      plane_rdy = 1'b0;
    end
  endtask

  task automatic push_exp(input logic [DataW-1:0] d, input logic [PlaneAw-1:0] p);
    exp_t e;
    e.data  = d;
    e.plane = p;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_plane", bus.out_plane, 0);
    check("rst_err", err, 0);
    check("rst_sat", sat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{bias: 16'd3, s0: 16'd5, s1: 16'hFFFE, s2: 16'd10, n: 3, exp: 16'd16,
                exp_sat: 1'b0};
    vecs[1] = '{bias: 16'd0, s0: 16'h7FFF, s1: 16'h7FFF, s2: 16'h7FFF, n: 3,
                exp: SatEn ? 16'h7FFF : 16'h7FFD, exp_sat: SatEn};
    vecs[2] = '{bias: 16'h0010, s0: 16'hFFF0, s1: 16'h0005, s2: 16'h0, n: 2, exp: 16'd5,
                exp_sat: SatEn};
    vecs[3] = '{bias: 16'h8000, s0: 16'hFFFF, s1: 16'h0, s2: 16'h0, n: 1,
                exp: SatEn ? 16'h8000 : 16'h7FFF, exp_sat: SatEn};
    vecs[4] = '{bias: 16'd100, s0: 16'hFF9C, s1: 16'd1, s2: 16'h0, n: 2, exp: 16'd1,
                exp_sat: SatEn};

    bus.in_valid   = 1'b0;
    bus.in_first   = 1'b0;
    bus.in_last    = 1'b0;
    bus.sum_muladd = '0;
    bus.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_err", err, 0);
    check("reset_sat", sat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame, with exact one-cycle valid pulse.
    write_bias(0, 16'd3);
    push_exp(16'd16, 0);
    send_beat(1'b1, 1'b0, 16'd5);
    send_beat(1'b0, 1'b0, 16'hFFFE);
    send_beat(1'b0, 1'b1, 16'd10);
    check("basic_valid_rise", bus.out_valid, 1);
    check("basic_data", bus.out_data, 16'd16);
    @(posedge clk);
    #1;
    check("basic_valid_fall", bus.out_valid, 0);
    check("basic_err", err, 0);
    wait_drain();

    for (int i = 0; i < 5; i++) begin
      write_bias(0, vecs[i].bias);
      if (vecs[i].n == 1) begin
        push_exp(vecs[i].exp, 0);
        send_beat(1'b1, 1'b1, vecs[i].s0);
      end else begin
        send_beat(1'b1, 1'b0, vecs[i].s0);
        if (vecs[i].n == 3) send_beat(1'b0, 1'b0, vecs[i].s1);
        push_exp(vecs[i].exp, 0);
        send_beat(1'b0, 1'b1, (vecs[i].n == 3) ? vecs[i].s2 : vecs[i].s1);
      end
      wait_drain();
      check("vec_sat", sat, vecs[i].exp_sat);
      check("vec_err", err, 0);
    end

    // Plane wrap.
    write_bias(5, 16'hFFFB);
    pulse_plane(5);
    push_exp(16'd2, 5);
    send_beat(1'b1, 1'b1, 16'h0007);
    wait_drain();
    pulse_plane(1);
    push_exp(16'd101, 0);
    send_beat(1'b1, 1'b1, 16'd1);
    wait_drain();

    // plane_rdy coinciding with a first beat at plane 1.
    pulse_plane(1);
    write_bias(1, 16'd50);
    write_bias(2, 16'd7);
    check("coinc_in_ready", bus.in_ready, 1);
    bus.in_valid   = 1'b1;
    bus.in_first   = 1'b1;
    bus.in_last    = 1'b0;
    bus.sum_muladd = 16'd10;
    plane_rdy      = 1'b1;
    @(posedge clk);
    #1;
    plane_rdy    = 1'b0;
    bus.in_valid = 1'b0;
    push_exp(16'd65, 1);
    send_beat(1'b0, 1'b1, 16'd5);
    push_exp(16'd7, 2);
    send_beat(1'b1, 1'b1, 16'd0);
    wait_drain();

    // Backpressure: result held, next beat stalled.
    bus.out_ready = 1'b0;
    push_exp(16'd27, 2);
    send_beat(1'b1, 1'b1, 16'd20);
    push_exp(16'd8, 2);
    bus.in_valid   = 1'b1;
    bus.in_first   = 1'b1;
    bus.in_last    = 1'b1;
    bus.sum_muladd = 16'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_data", bus.out_data, 16'd27);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    push_exp(16'd10, 2);
    send_beat(1'b1, 1'b1, 16'd3);
    wait_drain();
    check("bp_err", err, 0);

    // First beat inside an open frame restarts it and flags err.
    send_beat(1'b1, 1'b0, 16'd50);
    push_exp(16'd9, 2);
    send_beat(1'b1, 1'b1, 16'd2);
    wait_drain();
    check("restart_err", err, 1);

    // Reset with a pending result, then reset mid-frame.
    bus.out_ready = 1'b0;
    send_beat(1'b1, 1'b1, 16'd1);
    check("pre_rst_valid", bus.out_valid, 1);
    async_reset();
    bus.out_ready = 1'b1;
    send_beat(1'b1, 1'b0, 16'd3);
    async_reset();
    send_beat(1'b0, 1'b1, 16'd4);
    check("orphan_err", err, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("orphan_no_out", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
    push_exp(16'd9, 0);
    send_beat(1'b1, 1'b1, 16'd9);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
